ofm_writeback_buffer: RTL and testbench
=======================================

// Module: ofm_writeback_buffer
// PURPOSE
//  Downstream stage of the MB-block data controller. It accepts the muxed OFM write stream
//  (wr_en, address, data) and buffers it in a small FIFO. It drains that FIFO into the
//  next-layer feature RAM under a ready handshake. On done_compute it flushes the FIFO and
//  reports layer completion.
// PARAMETERS
//  DATA_W     128   width of one muxed OFM word (4 PE outputs x 32 bit)
//  ADDR_W     32    next-layer RAM address width
//  DEPTH      16    FIFO entries; must be a power of 2 and >= 4
//  BASE_ADDR  0     offset added to every incoming address (modulo 2^ADDR_W)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous reset, active-low
//  in_wr_en       in   1       upstream write strobe (controller wr_en_next)
//  in_addr        in   ADDR_W  upstream write address (controller addr_ram_next_wr)
//  in_data        in   DATA_W  muxed OFM word
//  done_compute   in   1       layer finished; request flush
//  ram_ready      in   1       next-layer RAM accepts a write this cycle
//  ram_wr_en      out  1       RAM write strobe (registered)
//  ram_addr       out  ADDR_W  RAM write address (registered)
//  ram_wr_data    out  DATA_W  RAM write data (registered)
//  fifo_full      out  1       FIFO holds DEPTH entries
//  overflow       out  1       sticky flag: a write was dropped
//  words_written  out  16      count of words issued to RAM in the current layer
//  layer_done     out  1       one-cycle pulse; flush complete
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE. Reset mid-operation discards FIFO contents.
//  FIFO: rd/wr pointers are log2(DEPTH)+1 bits.
//   - full when the pointers differ only in the MSB; empty when they are equal.
//   - Each entry stores {in_addr + BASE_ADDR, in_data}. The add truncates to ADDR_W, so it wraps.
//  Push: in_wr_en=1 and (not full, or a pop in the same cycle).
//   - in_wr_en=1 while full with no pop: the word is dropped, overflow<=1.
//   - overflow holds until reset or the next IDLE->RUN transition.
//  Pop: FIFO not empty and ram_ready=1.
//   - On the next edge: ram_wr_en<=1, ram_addr/ram_wr_data <= head entry, words_written += 1.
//   - Otherwise ram_wr_en<=0 and ram_addr/ram_wr_data hold their values.
//   - Minimum latency from push to ram_wr_en is 1 cycle: a word pushed at edge N is on the RAM port after edge N+1.
//   - Simultaneous push and pop at any occupancy keeps the count unchanged.
//  words_written wraps at 2^16.
//  FSM:
//   - IDLE : in_wr_en=1 -> RUN; words_written<=0, overflow<=0. The entering write is still pushed.
//   - RUN  : normal push/pop. done_compute=1 -> FLUSH.
//   - FLUSH: pushes are still accepted. When the FIFO is empty and no pop is issuing this cycle -> DONE.
//   - DONE : layer_done=1 for exactly this cycle, then -> IDLE. words_written holds its value.
//  done_compute in IDLE is ignored; no layer_done is produced.
//  done_compute together with in_wr_en in RUN: the word is pushed and the state goes to FLUSH.
//  fifo_full is combinational from the pointers.
// CONFIGURATION
//  OFM_WB_RELU_EN defined: each 32-bit lane of the word is clamped at push time.
//   - A negative signed lane is replaced by 0; other lanes pass unchanged.
//   - Latency is unchanged.
//  OFM_WB_RELU_EN undefined: data passes bit-exact.
// TESTING
//  T1 reset: rst_n low mid-burst -> ram_wr_en=0, fifo_full=0, overflow=0, words_written=0 immediately.
//  T2 streaming: ram_ready=1, 4 writes at addr 0..3, BASE_ADDR=0x100
//     -> ram_addr 0x100..0x103 on consecutive cycles, first one 1 cycle after the first push.
//  T3 backpressure: ram_ready=0, 16 pushes -> fifo_full=1; 17th push -> overflow=1 and that word is dropped.
//     Then ram_ready=1 -> exactly 16 RAM writes in order.
//  T4 flush: 5 words queued, ram_ready=1, done_compute pulsed
//     -> 5 writes, layer_done pulses once, words_written=5, state returns to IDLE.
//  T5 simultaneous: FIFO full with push and pop in the same cycle -> no drop, fifo_full stays 1.
//  T6 RELU (macro on): lane 0xFFFFFFF0 -> 0x00000000, lane 0x00000010 -> unchanged.
//     Macro off: both lanes pass unchanged.

Source files
------------

// File: rtl/ofm_writeback_buffer.sv
// ofm_writeback_buffer
//   Buffers the muxed OFM write stream from the MB-block data controller in a
//   small FIFO. It drains that FIFO into the next-layer feature RAM under a
//   ready handshake. On done_compute it flushes the FIFO and pulses layer_done.
//
// Parameters
//   DATA_W    width of one OFM word (a multiple of 32; one 32-bit lane per PE)
//   ADDR_W    RAM address width
//   DEPTH     FIFO entries (power of 2, >= 4)
//   BASE_ADDR offset added to every incoming address (wraps at 2^ADDR_W)
//
// Ports
//   clk, rst_n                   clock / async active-low reset
//   in_wr_en, in_addr, in_data   upstream write stream
//   done_compute                 layer finished, request flush
//   ram_ready                    RAM accepts a write this cycle
//   ram_wr_en, ram_addr,
//   ram_wr_data                  registered RAM write port
//   fifo_full                    FIFO holds DEPTH entries (combinational)
//   overflow                     sticky: a write was dropped
//   words_written                words issued to RAM this layer (wraps at 2^16)
//   layer_done                   one-cycle pulse when the flush completes
//
// Build option
//   OFM_WB_RELU_EN  clamp negative signed 32-bit lanes to 0 at push time.

module ofm_wb_lane_relu (
  input  logic [31:0] din,
  output logic [31:0] dout
);
`ifdef OFM_WB_RELU_EN
  assign dout = din[31] ? 32'd0 : din;
`else
  assign dout = din;
`endif
endmodule

module ofm_writeback_buffer #(
  parameter int unsigned          DATA_W    = 128,
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DEPTH     = 16,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_wr_en,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              done_compute,
  input  logic              ram_ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              fifo_full,
  output logic              overflow,
  output logic [15:0]       words_written,
  output logic              layer_done
);

  localparam int unsigned PW        = $clog2(DEPTH);
  localparam int unsigned NUM_LANES = DATA_W / 32;
  localparam int unsigned EW        = ADDR_W + DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [PW:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [DEPTH];

  logic fifo_empty, push, pop, drop, start;
  logic [ADDR_W-1:0] wr_addr;
  logic [NUM_LANES-1:0][31:0] lane_in, lane_out;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign pop   = !fifo_empty && ram_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push  = in_wr_en && (!fifo_full || pop);
  assign drop  = in_wr_en && fifo_full && !pop;
  assign start = (state == S_IDLE) && in_wr_en;

  assign wr_addr    = in_addr + BASE_ADDR;
  assign layer_done = (state == S_DONE);

  assign lane_in = in_data;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ofm_wb_lane_relu u_lane (
      .din  (lane_in[l]),
      .dout (lane_out[l])
    );
  end

  // Storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {wr_addr, lane_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ram_wr_en     <= 1'b0;
      ram_addr      <= '0;
      ram_wr_data   <= '0;
      overflow      <= 1'b0;
      words_written <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      ram_wr_en <= pop;
      if (pop) {ram_addr, ram_wr_data} <= mem[rd_ptr[PW-1:0]];

      // A new layer clears the counter; a pop in that same cycle still counts.
      if (start)    words_written <= pop ? 16'd1 : 16'd0;
      else if (pop) words_written <= words_written + 16'd1;

      overflow <= (start ? 1'b0 : overflow) | drop;

      case (state)
        S_IDLE:  if (in_wr_en)                state <= S_RUN;
        S_RUN:   if (done_compute)            state <= S_FLUSH;
        S_FLUSH: if (fifo_empty && !pop)      state <= S_DONE;
        S_DONE:                               state <= S_IDLE;
        default:                              state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writeback_buffer.sv
// Scoreboard bench for ofm_writeback_buffer (DEPTH=16, BASE_ADDR=0x100).
module tb_ofm_writeback_buffer;
  localparam logic [31:0] BASE = 32'h100;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_wr_en = 1'b0, done_compute = 1'b0, ram_ready = 1'b0;
  logic [31:0]  in_addr = '0;
  logic [127:0] in_data = '0;
  logic         ram_wr_en, fifo_full, overflow, layer_done;
  logic [31:0]  ram_addr;
  logic [127:0] ram_wr_data;
  logic [15:0]  words_written;

  ofm_writeback_buffer #(.DATA_W(128), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_wr_en(in_wr_en), .in_addr(in_addr), .in_data(in_data),
    .done_compute(done_compute), .ram_ready(ram_ready), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .fifo_full(fifo_full),
    .overflow(overflow), .words_written(words_written), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [127:0] d; } wr_t;
  wr_t exp_q[$];
  int  wr_cyc_q[$];
  int  total = 0, bad = 0, cyc = 0, n_wr = 0, n_done = 0;
  wr_t got_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every RAM write against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (layer_done) n_done++;
      if (ram_wr_en) begin
        n_wr++;
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h want none", ram_addr);
        end else begin
          got_e = exp_q.pop_front();
          chk("wr_addr", ram_addr, got_e.a);
          chk("wr_data", ram_wr_data, got_e.d);
        end
      end
    end
  end

  function automatic logic [127:0] w(input int i);
    logic [31:0] v;
    v = 32'h0100_0000 + i;
    return {4{v}};
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] ea,
                      input logic [127:0] d, input logic [127:0] ed, input bit acc);
    wr_t e;
    in_wr_en = 1'b1; in_addr = a; in_data = d;
    if (acc) begin e.a = ea; e.d = ed; exp_q.push_back(e); end
    @(posedge clk); #1;
    in_wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    done_compute = 1'b1;
    @(posedge clk); #1;
    done_compute = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int s;
    s = n_done;
    for (int i = 0; i < budget && n_done == s; i++) begin
      @(posedge clk); #1;
    end
    idle(3);
    chk(nm, n_done - s, 1);
  endtask

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || ram_wr_en); i++) begin
      @(posedge clk); #1;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    int e0, n0, d0;
    logic [127:0] raw6, exp6;

    // Reset state
    #1;
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ww", words_written, 0);
    chk("rst_done", layer_done, 0);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: reset mid-burst
    ram_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(i, i + BASE, w(i), w(i), 1);
    chk("t1_wr_before", ram_wr_en, 1);
    chk("t1_ww_before", words_written, 2);
    rst_n = 1'b0;
    #1;
    chk("t1_wr_en", ram_wr_en, 0);
    chk("t1_full", fifo_full, 0);
    chk("t1_ovf", overflow, 0);
    chk("t1_ww", words_written, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n0 = n_wr;
    idle(3);
    chk("t1_no_stale_writes", n_wr - n0, 0);

    // T2: streaming, first write one cycle after the first push
    wr_cyc_q.delete();
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) push(i, i + BASE, w(10 + i), w(10 + i), 1);
    idle(3);
    chk("t2_nwr", wr_cyc_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_cyc_q.size(); i++)
      chk("t2_wr_cycle", wr_cyc_q[i], e0 + 1 + i);
    pulse_done();
    wait_done("t2_layer_done", 20);
    chk("t2_ww", words_written, 4);

    // T3: backpressure, overflow, drain in order
    ram_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h10 + i, 32'h110 + i, w(20 + i), w(20 + i), 1);
    chk("t3_full", fifo_full, 1);
    chk("t3_ovf_clear", overflow, 0);
    push(32'h99, 32'h199, w(99), w(99), 0);
    chk("t3_ovf_set", overflow, 1);
    chk("t3_full_held", fifo_full, 1);
    n0 = n_wr;
    ram_ready = 1'b1;
    drain("t3_drain", 60);
    chk("t3_nwr", n_wr - n0, 16);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_not_full", fifo_full, 0);
    pulse_done();
    wait_done("t3_layer_done", 20);
    chk("t3_ww", words_written, 16);

    // T4: flush with 5 queued words, including an address that wraps
    ram_ready = 1'b0;
    push(32'hFFFF_FFFF, 32'h0000_00FF, w(40), w(40), 1);
    for (int i = 1; i < 5; i++) push(32'h40 + i, 32'h140 + i, w(40 + i), w(40 + i), 1);
    chk("t4_ovf_cleared", overflow, 0);
    n0 = n_wr;
    ram_ready = 1'b1;
    pulse_done();
    wait_done("t4_layer_done", 40);
    chk("t4_nwr", n_wr - n0, 5);
    chk("t4_ww", words_written, 5);
    idle(3);
    chk("t4_ww_hold", words_written, 5);
    d0 = n_done;
    pulse_done();   // ignored in IDLE
    idle(6);
    chk("t4_idle_done_ignored", n_done - d0, 0);

    // T5: full FIFO with push and pop in the same cycle
    ram_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h50 + i, 32'h150 + i, w(50 + i), w(50 + i), 1);
    chk("t5_full", fifo_full, 1);
    ram_ready = 1'b1;
    push(32'h60, 32'h160, w(66), w(66), 1);
    ram_ready = 1'b0;
    chk("t5_pop_issued", ram_wr_en, 1);
    chk("t5_still_full", fifo_full, 1);
    chk("t5_no_drop", overflow, 0);
    ram_ready = 1'b1;
    drain("t5_drain", 60);
    pulse_done();
    wait_done("t5_layer_done", 20);
    chk("t5_ww", words_written, 17);

    // T6: lane clamp (macro on) or bit-exact passthrough (macro off)
    raw6 = 128'h8000_0000_7FFF_FFFF_0000_0010_FFFF_FFF0;
`ifdef OFM_WB_RELU_EN
    exp6 = 128'h0000_0000_7FFF_FFFF_0000_0010_0000_0000;
`else
    exp6 = 128'h8000_0000_7FFF_FFFF_0000_0010_FFFF_FFF0;
`endif
    push(32'h5, 32'h105, raw6, exp6, 1);
    drain("t6_drain", 20);
    chk("t6_data_port", ram_wr_data, exp6);
    pulse_done();
    wait_done("t6_layer_done", 20);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
